// File: rtl/exponential_param_if.sv
// Start/done coprocessor bus for the iterative e^x engine.
// Result is int_part (2-bit integer) plus frac (FW-bit fraction).
interface exponential_param_if #(
  parameter int XW = 16,
  parameter int FW = 16
);
  logic          engStart;
  logic [XW-1:0] engX;
  logic          engDone;
  logic          engBusy;
  logic [1:0]    int_part;
  logic [FW-1:0] frac;

  modport master (
    output engStart, engX,
    input  engDone, engBusy, int_part, frac
  );

  modport slave (
    input  engStart, engX,
    output engDone, engBusy, int_part, frac
  );
endinterface

// File: rtl/exponential_param.sv
// Iterative e^x engine: truncated Taylor sum with one shared multiplier, two multiplies per term.
// Optional macro EXP_EARLY_EXIT_EN: finish as soon as a term truncates to zero.
module exponential_param #(
  parameter int XW    = 16,
  parameter int FW    = 16,
  parameter int TERMS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  exponential_param_if.slave   eng
);
  localparam int TW = FW + 1;
  localparam int AW = FW + 2;
  localparam int BW = (XW > TW) ? XW : TW;
  localparam int PW = TW + BW;

  localparam logic [TW-1:0] ONE_T = {1'b1, {FW{1'b0}}};
  localparam logic [AW-1:0] ONE_A = {2'b01, {FW{1'b0}}};

  typedef enum logic [1:0] {IDLE, MULX, MULR, DONE} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [TW-1:0] term_q, term_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [3:0]    k_q, k_d;
  logic [AW-1:0] res_q, res_d;

  // floor(2^FW / k); entry 0 is never addressed
  logic [TW-1:0] recip [16];
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_recip
      if (gi == 0) begin : g_zero
        assign recip[gi] = '0;
      end else begin : g_val
        assign recip[gi] = TW'((64'd1 << FW) / 64'(gi));
      end
    end
  endgenerate

  logic [BW-1:0] mul_b;
  logic [PW-1:0] prod;
  logic [TW-1:0] term_x;
  logic [TW-1:0] t;
  logic [AW-1:0] acc_sum;
  logic          last;

  // Shared multiplier: MULX scales by x, MULR divides by k via the reciprocal table
  assign mul_b   = (state_q == MULX) ? BW'(x_q) : BW'(recip[k_q]);
  assign prod    = PW'(term_q) * PW'(mul_b);
  assign term_x  = TW'(prod >> XW);
  assign t       = TW'(prod >> FW);
  assign acc_sum = acc_q + AW'(t);

`ifdef EXP_EARLY_EXIT_EN
  assign last = (k_q == 4'(TERMS)) || (t == '0);
`else
  assign last = (k_q == 4'(TERMS));
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    term_d  = term_q;
    acc_d   = acc_q;
    k_d     = k_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (eng.engStart) begin
          x_d     = eng.engX;
          term_d  = ONE_T;
          acc_d   = ONE_A;
          k_d     = 4'd1;
          state_d = MULX;
        end
      end
      MULX: begin
        term_d  = term_x;
        state_d = MULR;
      end
      MULR: begin
        term_d = t;
        acc_d  = acc_sum;
        if (last) begin
          res_d   = acc_sum;
          state_d = DONE;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = MULX;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      term_q  <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      term_q  <= term_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      res_q   <= res_d;
    end
  end

  assign eng.engDone  = (state_q == DONE);
  assign eng.engBusy  = (state_q != IDLE);
  assign eng.int_part = res_q[AW-1:FW];
  assign eng.frac     = res_q[FW-1:0];
endmodule

// File: tb/tb_exponential_param.sv
// Directed bench for exponential_param: default build plus TERMS=2, TERMS=15 and 24-bit variants.
module tb_exponential_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef EXP_EARLY_EXIT_EN
  localparam int LAT_HALF = 14;
  localparam int LAT_ZERO = 2;
  localparam int LAT_T15  = 14;
`else
  localparam int LAT_HALF = 16;
  localparam int LAT_ZERO = 16;
  localparam int LAT_T15  = 30;
`endif

  always #5 clk = ~clk;

  exponential_param_if #(.XW(16), .FW(16)) m_if ();
  exponential_param_if #(.XW(16), .FW(16)) if2 ();
  exponential_param_if #(.XW(16), .FW(16)) if15 ();
  exponential_param_if #(.XW(24), .FW(24)) if24 ();

  exponential_param #(.XW(16), .FW(16), .TERMS(8))  dut     (.clk(clk), .rst(rst), .eng(m_if.slave));
  exponential_param #(.XW(16), .FW(16), .TERMS(2))  dut_t2  (.clk(clk), .rst(rst), .eng(if2.slave));
  exponential_param #(.XW(16), .FW(16), .TERMS(15)) dut_t15 (.clk(clk), .rst(rst), .eng(if15.slave));
  exponential_param #(.XW(24), .FW(24), .TERMS(8))  dut_w24 (.clk(clk), .rst(rst), .eng(if24.slave));

  // Stimulus only: waits for IDLE, pulses start, counts edges until engDone.
  task automatic run_x(input logic [15:0] x, output int lat,
                       output logic [1:0] ri, output logic [15:0] rf);
    @(negedge clk);
    for (int i = 0; i < 50 && m_if.engBusy; i++) @(negedge clk);
    m_if.engX = x;
    m_if.engStart = 1'b1;
    @(posedge clk);
    #1 m_if.engStart = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (m_if.engDone) break;
    end
    ri = m_if.int_part;
    rf = m_if.frac;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({m_if.engDone, m_if.engBusy, m_if.int_part, m_if.frac} !== 20'h0) begin
      errors++;
      $display("FAIL reset: done=%b busy=%b int=%0d frac=%h, required all zero",
               m_if.engDone, m_if.engBusy, m_if.int_part, m_if.frac);
    end
    rst = 1'b0;
    $display("test_reset: done=%b busy=%b int=%0d frac=%h",
             m_if.engDone, m_if.engBusy, m_if.int_part, m_if.frac);
  endtask

  task automatic test_half();
    int lat; logic [1:0] ri; logic [15:0] rf;
    run_x(16'h8000, lat, ri, rf);
    $display("test_half: x=8000 lat=%0d int=%0d frac=%h", lat, ri, rf);
    checks++;
    if (lat !== LAT_HALF) begin
      errors++; $display("FAIL half_latency: got %0d, required %0d", lat, LAT_HALF);
    end
    checks++;
    if ({ri, rf} !== {2'd1, 16'hA610}) begin
      errors++; $display("FAIL half_result: got %0d.%h, required 1.a610", ri, rf);
    end
    @(posedge clk); #1;
    checks++;
    if (m_if.engDone !== 1'b0) begin
      errors++; $display("FAIL done_pulse: engDone=%b second cycle, required 0", m_if.engDone);
    end
  endtask

  task automatic test_values();
    int lat; logic [1:0] ri; logic [15:0] rf;
    run_x(16'hC000, lat, ri, rf);
    $display("test_values: x=c000 lat=%0d int=%0d frac=%h", lat, ri, rf);
    checks++;
    if ({ri, rf} !== {2'd2, 16'h1DEF} || lat !== 16) begin
      errors++; $display("FAIL x_c000: got %0d.%h lat %0d, required 2.1def lat 16", ri, rf, lat);
    end
    run_x(16'hFFFF, lat, ri, rf);
    $display("test_values: x=ffff lat=%0d int=%0d frac=%h", lat, ri, rf);
    checks++;
    if ({ri, rf} !== {2'd2, 16'hB7D9} || lat !== 16) begin
      errors++; $display("FAIL x_ffff: got %0d.%h lat %0d, required 2.b7d9 lat 16", ri, rf, lat);
    end
  endtask

  task automatic test_zero();
    int lat; logic [1:0] ri; logic [15:0] rf;
    run_x(16'h0000, lat, ri, rf);
    $display("test_zero: x=0000 lat=%0d int=%0d frac=%h", lat, ri, rf);
    checks++;
    if ({ri, rf} !== {2'd1, 16'h0000}) begin
      errors++; $display("FAIL x_zero: got %0d.%h, required 1.0000", ri, rf);
    end
    checks++;
    if (lat !== LAT_ZERO) begin
      errors++; $display("FAIL zero_latency: got %0d, required %0d", lat, LAT_ZERO);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    for (int i = 0; i < 50 && m_if.engBusy; i++) @(negedge clk);
    m_if.engX = 16'h8000;
    m_if.engStart = 1'b1;
    @(posedge clk);
    #1 m_if.engX = 16'hFFFF;
    checks++;
    if (m_if.engBusy !== 1'b1) begin
      errors++; $display("FAIL b2b_busy: engBusy=%b after accept, required 1", m_if.engBusy);
    end
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); lat++; #1;
      if (m_if.engDone) break;
    end
    $display("test_back_to_back: run1 lat=%0d int=%0d frac=%h", lat, m_if.int_part, m_if.frac);
    checks++;
    if (lat !== LAT_HALF || {m_if.int_part, m_if.frac} !== {2'd1, 16'hA610}) begin
      errors++; $display("FAIL b2b_first: got %0d.%h lat %0d, required 1.a610 lat %0d",
                         m_if.int_part, m_if.frac, lat, LAT_HALF);
    end
    @(posedge clk); #1;
    checks++;
    if (m_if.engBusy !== 1'b0 || m_if.engDone !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: busy=%b done=%b, required 0 0", m_if.engBusy, m_if.engDone);
    end
    @(posedge clk); #1;
    checks++;
    if (m_if.engBusy !== 1'b1) begin
      errors++; $display("FAIL b2b_restart: engBusy=%b, required 1", m_if.engBusy);
    end
    m_if.engStart = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); lat++; #1;
      if (m_if.engDone) break;
    end
    $display("test_back_to_back: run2 lat=%0d int=%0d frac=%h", lat, m_if.int_part, m_if.frac);
    checks++;
    if (lat !== 16 || {m_if.int_part, m_if.frac} !== {2'd2, 16'hB7D9}) begin
      errors++; $display("FAIL b2b_second: got %0d.%h lat %0d, required 2.b7d9 lat 16",
                         m_if.int_part, m_if.frac, lat);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones; int lat; logic [1:0] ri; logic [15:0] rf;
    @(negedge clk);
    for (int i = 0; i < 50 && m_if.engBusy; i++) @(negedge clk);
    m_if.engX = 16'h8000;
    m_if.engStart = 1'b1;
    @(posedge clk);
    #1 m_if.engStart = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("test_reset_mid_run: busy=%b done=%b int=%0d frac=%h",
             m_if.engBusy, m_if.engDone, m_if.int_part, m_if.frac);
    checks++;
    if ({m_if.engDone, m_if.engBusy, m_if.int_part, m_if.frac} !== 20'h0) begin
      errors++; $display("FAIL midrun_reset: done=%b busy=%b int=%0d frac=%h, required all zero",
                         m_if.engDone, m_if.engBusy, m_if.int_part, m_if.frac);
    end
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (m_if.engDone) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL midrun_no_done: saw %0d engDone pulses, required 0", dones);
    end
    run_x(16'hC000, lat, ri, rf);
    $display("test_reset_mid_run: fresh x=c000 lat=%0d int=%0d frac=%h", lat, ri, rf);
    checks++;
    if ({ri, rf} !== {2'd2, 16'h1DEF}) begin
      errors++; $display("FAIL midrun_fresh: got %0d.%h, required 2.1def", ri, rf);
    end
  endtask

  task automatic test_param_sweep();
    int cyc; int l2; int l15; int l24;
    logic [17:0] r2; logic [17:0] r15; logic [25:0] r24;
    l2 = 0; l15 = 0; l24 = 0; r2 = '0; r15 = '0; r24 = '0;
    @(negedge clk);
    if2.engX = 16'h8000;  if15.engX = 16'h8000;  if24.engX = 24'h800000;
    if2.engStart = 1'b1;  if15.engStart = 1'b1;  if24.engStart = 1'b1;
    @(posedge clk);
    #1;
    if2.engStart = 1'b0;  if15.engStart = 1'b0;  if24.engStart = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (if2.engDone && l2 == 0)   begin l2 = cyc;  r2 = {if2.int_part, if2.frac};   end
      if (if15.engDone && l15 == 0) begin l15 = cyc; r15 = {if15.int_part, if15.frac}; end
      if (if24.engDone && l24 == 0) begin l24 = cyc; r24 = {if24.int_part, if24.frac}; end
    end
    $display("test_param_sweep: T2 lat=%0d res=%h T15 lat=%0d res=%h W24 lat=%0d res=%h",
             l2, r2, l15, r15, l24, r24);
    checks++;
    if (l2 !== 4 || r2 !== {2'd1, 16'hA000}) begin
      errors++; $display("FAIL terms2: got %h lat %0d, required 1.a000 lat 4", r2, l2);
    end
    checks++;
    if (l15 !== LAT_T15 || r15 !== {2'd1, 16'hA610}) begin
      errors++; $display("FAIL terms15: got %h lat %0d, required 1.a610 lat %0d", r15, l15, LAT_T15);
    end
    checks++;
    if (l24 !== 16 || r24 !== {2'd1, 24'hA61294}) begin
      errors++; $display("FAIL width24: got %h lat %0d, required 1.a61294 lat 16", r24, l24);
    end
  endtask

  initial begin
    m_if.engStart = 1'b0; m_if.engX = '0;
    if2.engStart  = 1'b0; if2.engX  = '0;
    if15.engStart = 1'b0; if15.engX = '0;
    if24.engStart = 1'b0; if24.engX = '0;
    test_reset();
    test_half();
    test_values();
    test_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
